alarm_timekeeper: RTL and testbench
===================================

// Module: alarm_timekeeper
// PURPOSE
// - Downstream consumer of the 1 Hz divided clock. Samples it as data in the I_CLK domain and maintains
//   BCD time of day HH:MM:SS, plus an alarm time register.
// - Runs a ring/snooze/timeout state machine whose ringing output drives the buzzer/LED stage.
// - Single clock domain; the divided clock is never used as a clock here.
// PARAMETERS
// - RING_SECS    60   seconds ringing lasts before auto-stop (>=1)
// - SNOOZE_SECS  300  seconds of silence after snooze before re-ring (>=1)
// PORTS
// - I_CLK      in   1  system clock; sole clock of the block
// - rst        in   1  synchronous, active-high reset
// - tick_in    in   1  divided clock, synchronous to I_CLK; each rising edge = one second
// - set_time   in   1  1-cycle pulse: load time from set_hh/set_mm, ss <= 8'h00
// - set_alarm  in   1  1-cycle pulse: load alarm from set_hh/set_mm
// - set_hh     in   8  BCD hours 00-23
// - set_mm     in   8  BCD minutes 00-59
// - alarm_en   in   1  level; 0 forces IDLE and blocks triggering
// - snooze     in   1  1-cycle pulse, acted on only in RING
// - stop       in   1  1-cycle pulse, cancels RING or SNOOZE
// - hh,mm,ss   out  8  current BCD time
// - sec_pulse  out  1  1-cycle strobe, high on the cycle a tick edge is accepted
// - ringing    out  1  high while in RING
// BEHAVIOUR
// - Reset values:
//   - hh=mm=ss=8'h00; alarm=00:00; state=IDLE; ringing=0; sec_pulse=0; counters=0.
//   - tick_q resets to 1, so a tick_in held high at reset release is not an edge.
// - Edge detect:
//   - rise = tick_in & ~tick_q; tick_q <= tick_in every cycle.
//   - sec_pulse is combinational from rise (0 during rst).
// - Time update, on rise: ss+1 in BCD.
//   - 59 -> 00 carries into mm; mm 59 -> 00 carries into hh; hh 23 -> 00.
//   - New value visible the cycle after rise.
// - set_time:
//   - Beats rise in the same cycle; that tick is dropped, not deferred.
//   - Rejected (no change) if any nibble >9, set_hh >8'h23 or set_mm >8'h59.
//   - Same validation for set_alarm. set_time and set_alarm may coincide; both load.
// - FSM states: IDLE, RING, SNOOZE. Priority: rst > (stop | ~alarm_en) > snooze > timers.
//   - IDLE -> RING: on a rise cycle whose next time is alarm_hh:alarm_mm:00, with alarm_en=1.
//     ringing goes high together with the new time. set_time never triggers.
//   - RING: ring_cnt clears on entry and increments on each rise.
//     - rise with ring_cnt==RING_SECS-1 -> IDLE.
//     - snooze -> SNOOZE, snz_cnt <= SNOOZE_SECS.
//     - stop or ~alarm_en -> IDLE.
//   - SNOOZE: rise decrements snz_cnt; rise with snz_cnt==1 -> RING.
//     stop or ~alarm_en -> IDLE.
//   - A snooze pulse outside RING is ignored.
// - Counter widths: $clog2(RING_SECS+1) and $clog2(SNOOZE_SECS+1), unsigned, no wrap past limits.
// - Reset mid-RING/SNOOZE: next cycle IDLE, ringing=0, time cleared.
// STRUCTURE
// - Shared package alarm_pkg:
//   - state enum {IDLE, RING, SNOOZE};
//   - BCD limit constants (8'h59, 8'h23);
//   - function bcd_valid(hh, mm).
// - One sub-module bcd_mod_counter #(MAX_BCD):
//   - inputs inc, load, load_val; outputs q[7:0], carry;
//   - instantiated three times (59, 59, 23), chained by carry.
// - FSM, edge detect and alarm compare live in the top.
// TESTING (bench uses RING_SECS=4, SNOOZE_SECS=3)
// - Reset: rst 2 cycles with tick_in=1 -> hh/mm/ss=00, ringing=0, no sec_pulse on release.
// - Rollover: set_time 23:59, 59 rises -> ss=59; one more rise -> 00:00:00.
// - Trigger: alarm 07:30, en=1, set_time 07:29, 60 rises -> ringing=1 on cycle after the 60th rise, time 07:30:00.
// - Snooze: in RING pulse snooze -> ringing=0; 3 rises -> ringing=1; stop -> 0 next cycle.
// - Timeout: in RING, no input, 4 rises -> ringing=0 after 4th; stays IDLE through 07:31:00.
// - Conflicts: set_time 12:34 on a rise cycle -> 12:34:00, tick dropped; set_mm=8'h6A -> time unchanged.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types, BCD limits and BCD helpers for the alarm timekeeper.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } alarm_state_e;

   localparam logic [7:0] BCD_MAX_SEC  = 8'h59;
   localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
   localparam logic [7:0] BCD_MAX_HOUR = 8'h23;

   // True when hh:mm is a legal BCD time of day (every digit 0-9, hh<=23, mm<=59).
   function automatic logic bcd_valid(input logic [7:0] hh, input logic [7:0] mm);
      logic digits_ok;
      digits_ok = (hh[7:4] <= 4'd9) && (hh[3:0] <= 4'd9) &&
                  (mm[7:4] <= 4'd9) && (mm[3:0] <= 4'd9);
      return digits_ok && (hh <= BCD_MAX_HOUR) && (mm <= BCD_MAX_MIN);
   endfunction

   // Two-digit BCD increment that wraps to 00 after max_bcd.
   function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_bcd);
      logic [7:0] res;
      if (val == max_bcd) begin
         res = 8'h00;
      end else if (val[3:0] == 4'd9) begin
         res = {val[7:4] + 4'd1, 4'd0};
      end else begin
         res = {val[7:4], val[3:0] + 4'd1};
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (00..MAX_BCD) with synchronous load.
// carry flags the increment that wraps MAX_BCD back to 00, so counters chain.
module bcd_mod_counter
   import alarm_pkg::*;
#(
   parameter logic [7:0] MAX_BCD = 8'h59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] q,
   output logic       carry
);

   logic [7:0] q_q;
   logic [7:0] q_d;

   // Next value: a load overrides an increment in the same cycle.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (inc) begin
         q_d = bcd_inc(q_q, MAX_BCD);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= 8'h00;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign carry = inc & ~load & (q_q == MAX_BCD);

endmodule

// File: rtl/alarm_timekeeper.sv
// BCD time-of-day keeper with an alarm that rings, snoozes and times out.
// tick_in is a slow divided clock treated purely as data: each rising edge
// seen in the I_CLK domain advances the time by one second.
module alarm_timekeeper
   import alarm_pkg::*;
#(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300
) (
   input  logic       I_CLK,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       set_time,
   input  logic       set_alarm,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic       alarm_en,
   input  logic       snooze,
   input  logic       stop,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       sec_pulse,
   output logic       ringing
);

   localparam int RW = $clog2(RING_SECS + 1);
   localparam int SW = $clog2(SNOOZE_SECS + 1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
   localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SECS);

   logic          tick_q;
   logic          rise;
   logic          set_ok;
   logic          time_load;
   logic          alarm_load;
   logic          inc_ss;
   logic          ss_carry;
   logic          mm_carry;
   logic          hh_carry;
   logic [7:0]    mm_nx;
   logic [7:0]    hh_nx;
   logic          alarm_hit;
   logic          cancel;

   logic [7:0]    alarm_hh_q;
   logic [7:0]    alarm_mm_q;

   alarm_state_e  state_q;
   alarm_state_e  state_d;
   logic [RW-1:0] ring_cnt_q;
   logic [RW-1:0] ring_cnt_d;
   logic [SW-1:0] snz_cnt_q;
   logic [SW-1:0] snz_cnt_d;

   // Tick history for edge detection; resets high so a tick held high
   // across reset release is not mistaken for a new second.
   always_ff @(posedge I_CLK) begin
      if (rst) begin
         tick_q <= 1'b1;
      end else begin
         tick_q <= tick_in;
      end
   end

   assign rise      = tick_in & ~tick_q & ~rst;
   assign sec_pulse = rise;

   // A valid set command wins over a coincident second; that second is lost.
   assign set_ok     = bcd_valid(set_hh, set_mm);
   assign time_load  = set_time & set_ok;
   assign alarm_load = set_alarm & set_ok;
   assign inc_ss     = rise & ~time_load;

   bcd_mod_counter #(.MAX_BCD(BCD_MAX_SEC)) u_ss (
      .clk      (I_CLK),
      .rst      (rst),
      .inc      (inc_ss),
      .load     (time_load),
      .load_val (8'h00),
      .q        (ss),
      .carry    (ss_carry)
   );

   bcd_mod_counter #(.MAX_BCD(BCD_MAX_MIN)) u_mm (
      .clk      (I_CLK),
      .rst      (rst),
      .inc      (ss_carry),
      .load     (time_load),
      .load_val (set_mm),
      .q        (mm),
      .carry    (mm_carry)
   );

   bcd_mod_counter #(.MAX_BCD(BCD_MAX_HOUR)) u_hh (
      .clk      (I_CLK),
      .rst      (rst),
      .inc      (mm_carry),
      .load     (time_load),
      .load_val (set_hh),
      .q        (hh),
      .carry    (hh_carry)
   );

   // Alarm time register; loaded independently of (and possibly together with) the time.
   always_ff @(posedge I_CLK) begin
      if (rst) begin
         alarm_hh_q <= 8'h00;
         alarm_mm_q <= 8'h00;
      end else if (alarm_load) begin
         alarm_hh_q <= set_hh;
         alarm_mm_q <= set_mm;
      end
   end

   // The alarm fires on the second that rolls into alarm_hh:alarm_mm:00.
   // ss_carry already implies an accepted tick with ss at 59, so the next
   // ss is 00 and only hh:mm after the carry chain needs comparing.
   always_comb begin
      mm_nx = ss_carry ? bcd_inc(mm, BCD_MAX_MIN) : mm;
      if (hh_carry) begin
         hh_nx = 8'h00;
      end else if (mm_carry) begin
         hh_nx = bcd_inc(hh, BCD_MAX_HOUR);
      end else begin
         hh_nx = hh;
      end
      alarm_hit = ss_carry & (hh_nx == alarm_hh_q) & (mm_nx == alarm_mm_q);
   end

   assign cancel = stop | ~alarm_en;

   // FSM registers: state plus ring-elapsed and snooze-remaining counters.
   always_ff @(posedge I_CLK) begin
      if (rst) begin
         state_q    <= IDLE;
         ring_cnt_q <= '0;
         snz_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
         snz_cnt_q  <= snz_cnt_d;
      end
   end

   // FSM next state: cancel beats snooze, snooze beats the second timers.
   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      unique case (state_q)
         IDLE: begin
            ring_cnt_d = '0;
            if (!cancel && alarm_hit) begin
               state_d = RING;
            end
         end
         RING: begin
            if (cancel) begin
               state_d    = IDLE;
               ring_cnt_d = '0;
            end else if (snooze) begin
               state_d    = SNOOZE;
               snz_cnt_d  = SNZ_LOAD;
               ring_cnt_d = '0;
            end else if (rise) begin
               if (ring_cnt_q == RING_LAST) begin
                  state_d    = IDLE;
                  ring_cnt_d = '0;
               end else begin
                  ring_cnt_d = ring_cnt_q + RW'(1);
               end
            end
         end
         SNOOZE: begin
            if (cancel) begin
               state_d   = IDLE;
               snz_cnt_d = '0;
            end else if (rise) begin
               if (snz_cnt_q == SW'(1)) begin
                  state_d    = RING;
                  ring_cnt_d = '0;
                  snz_cnt_d  = '0;
               end else begin
                  snz_cnt_d = snz_cnt_q - SW'(1);
               end
            end
         end
         default: begin
            state_d    = IDLE;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
         end
      endcase
   end

   assign ringing = (state_q == RING);

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Self-checking bench for alarm_timekeeper. The reference model keeps time as
// seconds since midnight and the alarm as a seconds value, converting to BCD
// only when comparing against the design outputs.
module tb_alarm_timekeeper;

   localparam int RING_SECS   = 4;
   localparam int SNOOZE_SECS = 3;
   localparam int DAY         = 86400;
   localparam int S_IDLE      = 0;
   localparam int S_RING      = 1;
   localparam int S_SNZ       = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_in;
   logic       set_time;
   logic       set_alarm;
   logic [7:0] set_hh;
   logic [7:0] set_mm;
   logic       alarm_en;
   logic       snooze;
   logic       stop;
   logic [7:0] hh;
   logic [7:0] mm;
   logic [7:0] ss;
   logic       sec_pulse;
   logic       ringing;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int m_t;
   int m_alarm;
   int m_state;
   int m_ring_el;
   int m_snz_left;
   bit m_tick_prev;

   always #5 clk = ~clk;

   alarm_timekeeper #(
      .RING_SECS   (RING_SECS),
      .SNOOZE_SECS (SNOOZE_SECS)
   ) dut (
      .I_CLK     (clk),
      .rst       (rst),
      .tick_in   (tick_in),
      .set_time  (set_time),
      .set_alarm (set_alarm),
      .set_hh    (set_hh),
      .set_mm    (set_mm),
      .alarm_en  (alarm_en),
      .snooze    (snooze),
      .stop      (stop),
      .hh        (hh),
      .mm        (mm),
      .ss        (ss),
      .sec_pulse (sec_pulse),
      .ringing   (ringing)
   );

   function automatic int bcd2int(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] int2bcd(input int n);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(n / 10);
      ones = 4'(n % 10);
      return {tens, ones};
   endfunction

   function automatic bit set_ok(input logic [7:0] h, input logic [7:0] m);
      return (h[7:4] < 4'd10) && (h[3:0] < 4'd10) && (m[7:4] < 4'd10) && (m[3:0] < 4'd10) &&
             (bcd2int(h) < 24) && (bcd2int(m) < 60);
   endfunction

   function automatic logic [23:0] exp_time();
      return {int2bcd(m_t / 3600), int2bcd((m_t / 60) % 60), int2bcd(m_t % 60)};
   endfunction

   function automatic bit exp_ring();
      return (m_state == S_RING);
   endfunction

   function automatic bit exp_pulse();
      return !rst && tick_in && !m_tick_prev;
   endfunction

   // Advance the model by one clock using the inputs as they stand at the edge.
   task automatic model_step();
      bit rise;
      bit tv;
      bit av;
      bit cancel;
      int t_new;
      if (rst) begin
         m_t = 0; m_alarm = 0; m_state = S_IDLE;
         m_ring_el = 0; m_snz_left = 0; m_tick_prev = 1'b1;
         return;
      end
      rise = tick_in && !m_tick_prev;
      m_tick_prev = tick_in;
      tv = set_time && set_ok(set_hh, set_mm);
      av = set_alarm && set_ok(set_hh, set_mm);
      if (tv) t_new = bcd2int(set_hh) * 3600 + bcd2int(set_mm) * 60;
      else if (rise) t_new = (m_t + 1) % DAY;
      else t_new = m_t;
      cancel = stop || !alarm_en;
      case (m_state)
         S_IDLE: begin
            if (!cancel && rise && !tv && t_new == m_alarm) begin
               m_state = S_RING; m_ring_el = 0;
            end
         end
         S_RING: begin
            if (cancel) m_state = S_IDLE;
            else if (snooze) begin
               m_state = S_SNZ; m_snz_left = SNOOZE_SECS;
            end else if (rise) begin
               m_ring_el++;
               if (m_ring_el >= RING_SECS) m_state = S_IDLE;
            end
         end
         default: begin
            if (cancel) m_state = S_IDLE;
            else if (rise) begin
               m_snz_left--;
               if (m_snz_left == 0) begin
                  m_state = S_RING; m_ring_el = 0;
               end
            end
         end
      endcase
      m_t = t_new;
      if (av) m_alarm = bcd2int(set_hh) * 3600 + bcd2int(set_mm) * 60;
   endtask

   task automatic clk_cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      set_time  = 1'b0;
      set_alarm = 1'b0;
      snooze    = 1'b0;
      stop      = 1'b0;
   endtask

   task automatic one_second();
      tick_in = 1'b1;
      clk_cycle();
      tick_in = 1'b0;
      clk_cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1; tick_in = 1'b1;
      clk_cycle();
      clk_cycle();
      #1;
      n_cmp++;
      if (sec_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse_in_rst: got %b want 0", sec_pulse); end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (sec_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_release_pulse: got %b want 0", sec_pulse); end
      n_cmp++;
      if ({hh, mm, ss} !== 24'h000000) begin n_bad++; $display("FAIL reset_time: got %h want 000000", {hh, mm, ss}); end
      n_cmp++;
      if (ringing !== 1'b0) begin n_bad++; $display("FAIL reset_ringing: got %b want 0", ringing); end
      clk_cycle();
      n_cmp++;
      if ({hh, mm, ss} !== exp_time()) begin n_bad++; $display("FAIL reset_held_tick_time: got %h want %h", {hh, mm, ss}, exp_time()); end
      tick_in = 1'b0;
      clk_cycle();
      $display("[reset] time=%h:%h:%h ringing=%b", hh, mm, ss, ringing);
   endtask

   task automatic test_rollover();
      set_hh = 8'h23; set_mm = 8'h59; set_time = 1'b1;
      clk_cycle();
      n_cmp++;
      if ({hh, mm, ss} !== 24'h235900) begin n_bad++; $display("FAIL rollover_set: got %h want 235900", {hh, mm, ss}); end
      repeat (59) one_second();
      n_cmp++;
      if ({hh, mm, ss} !== 24'h235959) begin n_bad++; $display("FAIL rollover_59: got %h want 235959", {hh, mm, ss}); end
      tick_in = 1'b1;
      #1;
      n_cmp++;
      if (sec_pulse !== 1'b1) begin n_bad++; $display("FAIL rollover_pulse: got %b want 1", sec_pulse); end
      clk_cycle();
      n_cmp++;
      if ({hh, mm, ss} !== 24'h000000) begin n_bad++; $display("FAIL rollover_midnight: got %h want 000000", {hh, mm, ss}); end
      n_cmp++;
      if (sec_pulse !== 1'b0) begin n_bad++; $display("FAIL rollover_pulse_width: got %b want 0", sec_pulse); end
      tick_in = 1'b0;
      clk_cycle();
      $display("[rollover] time=%h:%h:%h", hh, mm, ss);
   endtask

   // Sets the time to hh:mm-1 of a 07:30 alarm and runs 60 seconds into RING.
   task automatic run_to_alarm(input string tag);
      set_hh = 8'h07; set_mm = 8'h29; set_time = 1'b1;
      clk_cycle();
      for (int s = 0; s < 59; s++) begin
         one_second();
         n_cmp++;
         if (ringing !== 1'b0) begin n_bad++; $display("FAIL %s_early_ring: sec %0d got %b want 0", tag, s, ringing); end
      end
      n_cmp++;
      if ({hh, mm, ss} !== 24'h072959) begin n_bad++; $display("FAIL %s_pre_time: got %h want 072959", tag, {hh, mm, ss}); end
      tick_in = 1'b1;
      clk_cycle();
      n_cmp++;
      if (ringing !== 1'b1) begin n_bad++; $display("FAIL %s_ring: got %b want 1", tag, ringing); end
      n_cmp++;
      if ({hh, mm, ss} !== 24'h073000) begin n_bad++; $display("FAIL %s_ring_time: got %h want 073000", tag, {hh, mm, ss}); end
      tick_in = 1'b0;
      clk_cycle();
      $display("[%s] alarm ringing=%b at %h:%h:%h", tag, ringing, hh, mm, ss);
   endtask

   task automatic test_trigger();
      alarm_en = 1'b1;
      set_hh = 8'h07; set_mm = 8'h30; set_alarm = 1'b1;
      clk_cycle();
      run_to_alarm("trigger");
   endtask

   task automatic test_snooze();
      snooze = 1'b1;
      clk_cycle();
      n_cmp++;
      if (ringing !== 1'b0) begin n_bad++; $display("FAIL snooze_silence: got %b want 0", ringing); end
      repeat (SNOOZE_SECS - 1) begin
         one_second();
         n_cmp++;
         if (ringing !== 1'b0) begin n_bad++; $display("FAIL snooze_early: got %b want 0", ringing); end
      end
      snooze = 1'b1;
      clk_cycle();
      n_cmp++;
      if (ringing !== 1'b0) begin n_bad++; $display("FAIL snooze_ignored_in_snooze: got %b want 0", ringing); end
      tick_in = 1'b1;
      clk_cycle();
      n_cmp++;
      if (ringing !== 1'b1) begin n_bad++; $display("FAIL snooze_rering: got %b want 1", ringing); end
      tick_in = 1'b0;
      stop = 1'b1;
      clk_cycle();
      n_cmp++;
      if (ringing !== 1'b0) begin n_bad++; $display("FAIL snooze_stop: got %b want 0", ringing); end
      $display("[snooze] stopped at %h:%h:%h ringing=%b", hh, mm, ss, ringing);
   endtask

   task automatic test_timeout();
      run_to_alarm("timeout");
      for (int s = 1; s < RING_SECS; s++) begin
         one_second();
         n_cmp++;
         if (ringing !== 1'b1) begin n_bad++; $display("FAIL timeout_still_ring: sec %0d got %b want 1", s, ringing); end
      end
      tick_in = 1'b1;
      clk_cycle();
      n_cmp++;
      if (ringing !== 1'b0) begin n_bad++; $display("FAIL timeout_stop: got %b want 0", ringing); end
      tick_in = 1'b0;
      clk_cycle();
      while ({hh, mm, ss} !== 24'h073100 && m_t < 7 * 3600 + 31 * 60) begin
         one_second();
         n_cmp++;
         if (ringing !== exp_ring()) begin n_bad++; $display("FAIL timeout_idle: got %b want %b", ringing, exp_ring()); end
      end
      n_cmp++;
      if ({hh, mm, ss} !== 24'h073100) begin n_bad++; $display("FAIL timeout_end_time: got %h want 073100", {hh, mm, ss}); end
      $display("[timeout] time=%h:%h:%h ringing=%b", hh, mm, ss, ringing);
   endtask

   task automatic test_conflicts();
      logic [15:0] bad_tbl [5];
      bad_tbl[0] = 16'h1260; bad_tbl[1] = 16'h126A; bad_tbl[2] = 16'h2400;
      bad_tbl[3] = 16'h0A10; bad_tbl[4] = 16'hF000;
      set_hh = 8'h12; set_mm = 8'h34; set_time = 1'b1; tick_in = 1'b1;
      #1;
      n_cmp++;
      if (sec_pulse !== 1'b1) begin n_bad++; $display("FAIL conflict_pulse: got %b want 1", sec_pulse); end
      clk_cycle();
      n_cmp++;
      if ({hh, mm, ss} !== 24'h123400) begin n_bad++; $display("FAIL conflict_tick_dropped: got %h want 123400", {hh, mm, ss}); end
      tick_in = 1'b0;
      clk_cycle();
      for (int i = 0; i < 5; i++) begin
         {set_hh, set_mm} = bad_tbl[i];
         set_time = 1'b1;
         clk_cycle();
         n_cmp++;
         if ({hh, mm, ss} !== 24'h123400) begin n_bad++; $display("FAIL conflict_reject_%0d: got %h want 123400", i, {hh, mm, ss}); end
      end
      // time and alarm loaded together, then alarm_en drop while ringing
      set_hh = 8'h08; set_mm = 8'h15; set_time = 1'b1; set_alarm = 1'b1;
      clk_cycle();
      n_cmp++;
      if ({hh, mm, ss} !== 24'h081500) begin n_bad++; $display("FAIL conflict_both_time: got %h want 081500", {hh, mm, ss}); end
      n_cmp++;
      if (ringing !== 1'b0) begin n_bad++; $display("FAIL conflict_set_no_trigger: got %b want 0", ringing); end
      set_hh = 8'h08; set_mm = 8'h14; set_time = 1'b1;
      clk_cycle();
      repeat (60) one_second();
      n_cmp++;
      if (ringing !== 1'b1) begin n_bad++; $display("FAIL conflict_both_alarm: got %b want 1", ringing); end
      alarm_en = 1'b0;
      clk_cycle();
      n_cmp++;
      if (ringing !== 1'b0) begin n_bad++; $display("FAIL conflict_en_off: got %b want 0", ringing); end
      alarm_en = 1'b1;
      clk_cycle();
      $display("[conflicts] time=%h:%h:%h ringing=%b", hh, mm, ss, ringing);
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         int op;
         int nm;
         op = $urandom_range(0, 199);
         if ($urandom_range(0, 9) < 8) tick_in = ~tick_in;
         alarm_en = ($urandom_range(0, 49) != 0);
         rst = (op == 0);
         if (op == 1) begin
            if ($urandom_range(0, 1) == 1) begin
               set_hh = int2bcd($urandom_range(0, 23)); set_mm = int2bcd($urandom_range(0, 59));
            end else begin
               set_hh = 8'($urandom); set_mm = 8'($urandom);
            end
            set_time = 1'b1;
            tick_in = m_tick_prev;
         end else if (op <= 3) begin
            nm = ((m_t / 60) + 1) % 1440;
            set_hh = int2bcd(nm / 60); set_mm = int2bcd(nm % 60);
            set_alarm = 1'b1;
         end else if (op <= 13) begin
            snooze = 1'b1;
         end else if (op == 14) begin
            stop = 1'b1;
         end
         #1;
         n_cmp++;
         if (sec_pulse !== exp_pulse()) begin n_bad++; $display("FAIL rand_pulse[%0d]: got %b want %b", i, sec_pulse, exp_pulse()); end
         clk_cycle();
         rst = 1'b0;
         n_cmp++;
         if ({hh, mm, ss} !== exp_time()) begin n_bad++; $display("FAIL rand_time[%0d]: got %h want %h", i, {hh, mm, ss}, exp_time()); end
         n_cmp++;
         if (ringing !== exp_ring()) begin n_bad++; $display("FAIL rand_ring[%0d]: got %b want %b", i, ringing, exp_ring()); end
         $display("[rand %0d] op=%0d time=%h:%h:%h ringing=%b", i, op, hh, mm, ss, ringing);
      end
   endtask

   initial begin
      rst = 1'b1; tick_in = 1'b1; set_time = 1'b0; set_alarm = 1'b0;
      set_hh = 8'h00; set_mm = 8'h00; alarm_en = 1'b0; snooze = 1'b0; stop = 1'b0;
      m_t = 0; m_alarm = 0; m_state = S_IDLE; m_ring_el = 0; m_snz_left = 0; m_tick_prev = 1'b1;
      test_reset();
      test_rollover();
      test_trigger();
      test_snooze();
      test_timeout();
      test_conflicts();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
